// File: rtl/fetch_redirect_ctrl_if.sv
// Redirect request/response bundle between the redirect sources and fetch.
// The master side drives the event sources and fetch_ack. The slave side is the redirect controller.
interface fetch_redirect_ctrl_if #(
    parameter int ADDR_W = 32
);
    logic              excp_valid;
    logic [ADDR_W-1:0] excp_eip;
    logic              mispred_valid;
    logic [ADDR_W-1:0] mispred_eip;
    logic              cs_inv;
    logic [ADDR_W-1:0] cs_neip;
    logic              intr;
    logic [ADDR_W-1:0] intr_vec;
    logic              pipe_clean;
    logic              fetch_ack;
    logic              flush_fe;
    logic              fetch_hold;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_eip;
    logic [1:0]        redirect_src;
    logic              intr_ack;

    modport master (
        output excp_valid, excp_eip, mispred_valid, mispred_eip, cs_inv, cs_neip,
               intr, intr_vec, pipe_clean, fetch_ack,
        input  flush_fe, fetch_hold, redirect_valid, redirect_eip, redirect_src, intr_ack
    );

    modport slave (
        input  excp_valid, excp_eip, mispred_valid, mispred_eip, cs_inv, cs_neip,
               intr, intr_vec, pipe_clean, fetch_ack,
        output flush_fe, fetch_hold, redirect_valid, redirect_eip, redirect_src, intr_ack
    );
endinterface

// File: rtl/fetch_redirect_ctrl.sv
// Front-end redirect sequencer: picks a redirect by priority, flushes the front end for a
// fixed window, then holds the new EIP until fetch takes it.
//
// state    | meaning
// IDLE     | no redirect pending, fetch runs freely
// DRAIN    | interrupt pending, waiting for older instructions to retire
// FLUSH    | flush_fe asserted, count runs down to the redirect
// REDIRECT | redirect_eip presented until fetch_ack
module fetch_redirect_ctrl #(
    parameter int FLUSH_CYCLES = 2,
    parameter int ADDR_W       = 32
) (
    input  logic CLK,
    input  logic reset,
    fetch_redirect_ctrl_if.slave rif
);
    typedef enum logic [1:0] {IDLE, DRAIN, FLUSH, REDIRECT} state_t;

    localparam logic [3:0] CNT_INIT = 4'(FLUSH_CYCLES - 1);

    state_t            state;
    logic [3:0]        count;
    logic [ADDR_W-1:0] lat_eip;
    logic [1:0]        lat_src;

    logic              sync_evt;
    logic              keep_excp;
    logic              restart;
    logic              enter_intr;
    logic [ADDR_W-1:0] win_eip;
    logic [1:0]        win_src;

    always_comb begin
        win_eip = rif.cs_neip;
        win_src = 2'd2;
        if (rif.excp_valid) begin
            win_eip = rif.excp_eip;
            win_src = 2'd0;
        end else if (rif.mispred_valid) begin
            win_eip = rif.mispred_eip;
            win_src = 2'd1;
        end
        sync_evt = rif.excp_valid | rif.mispred_valid | rif.cs_inv;
        // A second exception must not overwrite the handler EIP of one already in progress.
        keep_excp = ((state == FLUSH) || (state == REDIRECT)) && (lat_src == 2'd0)
                    && rif.excp_valid;
        restart    = sync_evt && !keep_excp;
        enter_intr = (state == DRAIN) && !sync_evt && rif.pipe_clean;
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state              <= IDLE;
            count              <= 4'd0;
            lat_eip            <= '0;
            lat_src            <= 2'd0;
            rif.flush_fe       <= 1'b0;
            rif.fetch_hold     <= 1'b0;
            rif.redirect_valid <= 1'b0;
            rif.redirect_eip   <= '0;
            rif.redirect_src   <= 2'd0;
            rif.intr_ack       <= 1'b0;
        end else begin
            rif.intr_ack <= 1'b0;
            if (restart || enter_intr) begin
                state              <= FLUSH;
                count              <= CNT_INIT;
                lat_eip            <= restart ? win_eip : rif.intr_vec;
                lat_src            <= restart ? win_src : 2'd3;
                rif.flush_fe       <= 1'b1;
                rif.fetch_hold     <= 1'b1;
                rif.redirect_valid <= 1'b0;
                rif.redirect_eip   <= '0;
                rif.redirect_src   <= 2'd0;
                rif.intr_ack       <= enter_intr;
            end else begin
                case (state)
                    IDLE: begin
                        if (rif.intr) begin
                            state          <= DRAIN;
                            rif.fetch_hold <= 1'b1;
                        end
                    end
                    DRAIN: begin
                        state <= DRAIN;
                    end
                    FLUSH: begin
                        if (count == 4'd0) begin
                            state              <= REDIRECT;
                            rif.flush_fe       <= 1'b0;
                            rif.redirect_valid <= 1'b1;
                            rif.redirect_eip   <= lat_eip;
                            rif.redirect_src   <= lat_src;
                        end else begin
                            count <= count - 4'd1;
                        end
                    end
                    REDIRECT: begin
                        if (rif.fetch_ack) begin
                            state              <= IDLE;
                            rif.fetch_hold     <= 1'b0;
                            rif.redirect_valid <= 1'b0;
                            rif.redirect_eip   <= '0;
                            rif.redirect_src   <= 2'd0;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// Scoreboard bench for fetch_redirect_ctrl: a cycle-level reference model predicts the
// outputs after each edge, and a monitor compares them one cycle at a time.
module tb_fetch_redirect_ctrl;
    localparam int FC = 2;
    localparam int AW = 32;

    typedef logic [37:0] obs_t;

    logic CLK = 1'b0;
    logic reset = 1'b0;
    always #5 CLK = ~CLK;

    fetch_redirect_ctrl_if #(.ADDR_W(AW)) rif ();

    fetch_redirect_ctrl #(.FLUSH_CYCLES(FC), .ADDR_W(AW)) dut (
        .CLK   (CLK),
        .reset (reset),
        .rif   (rif)
    );

    obs_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: plain bookkeeping of what the front end should see.
    bit          m_draining;
    bit          m_red;
    bit          m_ack;
    int          m_flush_left;
    logic [1:0]  m_src;
    logic [31:0] m_eip;

    function automatic obs_t model_out();
        logic hold;
        hold = m_draining || (m_flush_left > 0) || m_red;
        return {1'(m_flush_left > 0), hold, m_red, m_ack,
                m_red ? m_src : 2'd0, m_red ? m_eip : 32'd0};
    endfunction

    task automatic model_step();
        bit          sync, latched, accept;
        logic [31:0] w_eip;
        logic [1:0]  w_src;
        if (!reset) begin
            m_draining = 0; m_red = 0; m_ack = 0; m_flush_left = 0;
            m_src = 0; m_eip = 0;
            return;
        end
        sync = rif.excp_valid || rif.mispred_valid || rif.cs_inv;
        if (rif.excp_valid)         begin w_eip = rif.excp_eip;    w_src = 2'd0; end
        else if (rif.mispred_valid) begin w_eip = rif.mispred_eip; w_src = 2'd1; end
        else                        begin w_eip = rif.cs_neip;     w_src = 2'd2; end
        latched = (m_flush_left > 0) || m_red;
        accept  = sync && !(latched && rif.excp_valid && m_src == 2'd0);
        m_ack = 0;
        if (accept) begin
            m_src = w_src; m_eip = w_eip; m_flush_left = FC; m_red = 0; m_draining = 0;
        end else if (m_draining && rif.pipe_clean) begin
            m_src = 2'd3; m_eip = rif.intr_vec; m_flush_left = FC; m_red = 0;
            m_draining = 0; m_ack = 1;
        end else if (m_flush_left > 1) begin
            m_flush_left--;
        end else if (m_flush_left == 1) begin
            m_flush_left = 0; m_red = 1;
        end else if (m_red) begin
            if (rif.fetch_ack) m_red = 0;
        end else if (!m_draining && rif.intr) begin
            m_draining = 1;
        end
    endtask

    // Called at a falling edge with inputs already set for the next rising edge.
    task automatic tick();
        model_step();
        sb.push_back(model_out());
        @(negedge CLK);
    endtask

    task automatic clr();
        rif.excp_valid = 0; rif.excp_eip = 0;
        rif.mispred_valid = 0; rif.mispred_eip = 0;
        rif.cs_inv = 0; rif.cs_neip = 0;
        rif.intr = 0; rif.intr_vec = 0;
        rif.pipe_clean = 0; rif.fetch_ack = 0;
    endtask

    task automatic ack_and_idle();
        rif.fetch_ack = 1;
        tick();
        rif.fetch_ack = 0;
        tick();
    endtask

    obs_t mon_exp, mon_act;
    initial begin
        forever begin
            @(posedge CLK);
            #1;
            if (sb.size() > 0) begin
                mon_exp = sb.pop_front();
                mon_act = {rif.flush_fe, rif.fetch_hold, rif.redirect_valid, rif.intr_ack,
                           rif.redirect_src, rif.redirect_eip};
                checks++;
                if (mon_act !== mon_exp) begin
                    errors++;
                    $display("FAIL cycle_outputs t=%0t {flush,hold,rv,iack,src,eip} actual=%h required=%h",
                             $time, mon_act, mon_exp);
                end
            end
        end
    end

    initial begin
        obs_t now;
        clr();
        reset = 0;
        @(negedge CLK);
        tick();
        tick();
        reset = 1;

        // single mispredict
        rif.mispred_valid = 1; rif.mispred_eip = 32'h1040;
        tick();
        clr();
        repeat (4) tick();
        ack_and_idle();

        // three sources together
        rif.excp_valid = 1; rif.excp_eip = 32'h2000;
        rif.mispred_valid = 1; rif.mispred_eip = 32'h1040;
        rif.cs_inv = 1; rif.cs_neip = 32'h3000;
        tick();
        clr();
        repeat (3) tick();
        ack_and_idle();

        // interrupt with drain
        rif.intr = 1; rif.intr_vec = 32'h0800;
        repeat (5) tick();
        rif.pipe_clean = 1;
        tick();
        rif.pipe_clean = 0; rif.intr = 0;
        repeat (3) tick();
        ack_and_idle();

        // cs_inv restarts a mispredict flush
        rif.mispred_valid = 1; rif.mispred_eip = 32'h1040;
        tick();
        clr();
        tick();
        rif.cs_inv = 1; rif.cs_neip = 32'h3000;
        tick();
        clr();
        repeat (3) tick();
        ack_and_idle();

        // preempt on the same edge as fetch_ack
        rif.mispred_valid = 1; rif.mispred_eip = 32'h1040;
        tick();
        clr();
        repeat (3) tick();
        rif.fetch_ack = 1; rif.mispred_valid = 1; rif.mispred_eip = 32'h5000;
        tick();
        clr();
        repeat (3) tick();
        ack_and_idle();

        // async reset mid-flush
        rif.mispred_valid = 1; rif.mispred_eip = 32'h1040;
        tick();
        clr();
        #2 reset = 0;
        #1;
        now = {rif.flush_fe, rif.fetch_hold, rif.redirect_valid, rif.intr_ack,
               rif.redirect_src, rif.redirect_eip};
        checks++;
        if (now !== '0) begin
            errors++;
            $display("FAIL async_reset actual=%h required=0", now);
        end
        tick();
        reset = 1;
        repeat (3) tick();

        // randomized traffic
        for (int i = 0; i < 1500; i++) begin
            rif.excp_valid    = ($urandom_range(0, 99) < 4);
            rif.excp_eip      = $urandom;
            rif.mispred_valid = ($urandom_range(0, 99) < 6);
            rif.mispred_eip   = $urandom;
            rif.cs_inv        = ($urandom_range(0, 99) < 4);
            rif.cs_neip       = $urandom;
            if ($urandom_range(0, 99) < 5) rif.intr = ~rif.intr;
            rif.intr_vec      = $urandom;
            rif.pipe_clean    = ($urandom_range(0, 99) < 30);
            rif.fetch_ack     = ($urandom_range(0, 99) < 40);
            tick();
        end

        clr();
        rif.fetch_ack = 1;
        repeat (10) tick();
        clr();
        tick();
        @(posedge CLK);
        #2;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
